// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU results take priority and load responses queue in an in-order FIFO.
// Define WB_STALL_COUNT_EN to add the stall_count output, which counts cycles where the ALU blocks pending loads.
module wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     rf_we,
    output logic [ADDRESS_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    input  logic [ADDRESS_WIDTH-1:0] chk_addr,
    output logic                     chk_hit,
    output logic                     busy
`ifdef WB_STALL_COUNT_EN
    ,
    output logic [31:0]              stall_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     rf_we_q, rf_we_d;
    logic [ADDRESS_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]    rf_wdata_q, rf_wdata_d;

    logic [ADDRESS_WIDTH-1:0] mem_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]    mem_data_q [DEPTH];

    logic                     push;
    logic                     pop;
    logic                     sel_valid;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [PW-1:0]            hit_ofs;
    logic                     hit_any;

    always_comb begin
        ld_ready  = rst_n && (count_q < CW'(DEPTH));
        push      = ld_valid && ld_ready;
        pop       = !alu_valid && (count_q != '0);
        sel_valid = alu_valid || pop;
        sel_addr  = alu_valid ? alu_addr : mem_addr_q[rd_ptr_q];
        sel_data  = alu_valid ? alu_data : mem_data_q[rd_ptr_q];

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Address-0 writes are still consumed but never reach the register file.
        rf_we_d    = sel_valid && (sel_addr != '0);
        rf_waddr_d = rf_we_d ? sel_addr : rf_waddr_q;
        rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        hit_any = 1'b0;
        hit_ofs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_ofs = PW'(i) - rd_ptr_q;
            if (({1'b0, hit_ofs} < count_q) && (mem_addr_q[i] == chk_addr))
                hit_any = 1'b1;
        end
        chk_hit = rst_n && hit_any && (chk_addr != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= ld_addr;
            mem_data_q[wr_ptr_q] <= ld_data;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = (count_q != '0);

`ifdef WB_STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (alu_valid && (count_q != '0) && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised self-checking bench for wb_arbiter against a queue-based write-back model.
module tb_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] chk_addr;
    logic          chk_hit;
    logic          busy;
`ifdef WB_STALL_COUNT_EN
    logic [31:0]   stall_count;
`endif

    wb_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .busy(busy)
`ifdef WB_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [31:0]   m_stall;
    int            compared;
    int            mismatched;

    task automatic model_reset();
        mq.delete();
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_stall = '0;
    endtask

    // One clock of traffic: drive just after the falling edge, check the
    // combinational outputs before the rising edge, then the registered ones.
    task automatic do_cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                            input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                            input logic [AW-1:0] ca);
        logic e_ready, e_busy, e_hit, have;
        ent_t w;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
        chk_addr  = ca;
        #1;
        e_ready = (mq.size() < DEPTH);
        e_busy  = (mq.size() != 0);
        e_hit   = 1'b0;
        if (ca != '0)
            foreach (mq[i]) if (mq[i].a == ca) e_hit = 1'b1;
        if (ld_ready !== e_ready) begin
            mismatched++;
            $display("[TB] FAIL ld_ready: got %0b expected %0b at %0t", ld_ready, e_ready, $time);
        end
        compared++;
        if (busy !== e_busy) begin
            mismatched++;
            $display("[TB] FAIL busy: got %0b expected %0b at %0t", busy, e_busy, $time);
        end
        compared++;
        if (chk_hit !== e_hit) begin
            mismatched++;
            $display("[TB] FAIL chk_hit: got %0b expected %0b (chk_addr %0d) at %0t", chk_hit, e_hit, ca, $time);
        end
        compared++;
        @(posedge clk);
        have = 1'b0;
        w    = '0;
        if (av) begin
            w = '{a: aa, d: ad};
            have = 1'b1;
        end else if (mq.size() > 0) begin
            w = mq.pop_front();
            have = 1'b1;
        end
        if (lv && e_ready) mq.push_back('{a: la, d: ldd});
        if (av && e_busy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (have && w.a != '0) begin
            m_we = 1'b1; m_waddr = w.a; m_wdata = w.d;
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
        if (rf_we !== m_we) begin
            mismatched++;
            $display("[TB] FAIL rf_we: got %0b expected %0b at %0t", rf_we, m_we, $time);
        end
        compared++;
        if (rf_waddr !== m_waddr) begin
            mismatched++;
            $display("[TB] FAIL rf_waddr: got %0d expected %0d at %0t", rf_waddr, m_waddr, $time);
        end
        compared++;
        if (rf_wdata !== m_wdata) begin
            mismatched++;
            $display("[TB] FAIL rf_wdata: got %h expected %h at %0t", rf_wdata, m_wdata, $time);
        end
        compared++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'h1234;
        chk_addr = 5'd3;
        model_reset();
        repeat (3) @(negedge clk);
        if ({ld_ready, busy, chk_hit, rf_we} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got ld_ready/busy/chk_hit/rf_we=%b expected 0000", {ld_ready, busy, chk_hit, rf_we});
        end
        compared++;
        if (rf_waddr !== '0 || rf_wdata !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got waddr %0d wdata %h expected 0 0", rf_waddr, rf_wdata);
        end
        compared++;
        ld_valid = 1'b0;
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_alu_write();
        do_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, '0);
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL alu_write: got we %0b addr %0d data %h expected 1 5 deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        compared++;
        idle_cycles(1);
    endtask

    task automatic test_load_latency();
        do_cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h11, '0);
        if (busy !== 1'b1 || rf_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL load_n1: got busy %0b rf_we %0b expected 1 0", busy, rf_we);
        end
        compared++;
        idle_cycles(1);
        if (busy !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11) begin
            mismatched++;
            $display("[TB] FAIL load_n2: got busy %0b we %0b addr %0d data %h expected 0 1 7 11", busy, rf_we, rf_waddr, rf_wdata);
        end
        compared++;
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            do_cycle(1'b1, 5'(1 + $urandom_range(0, 30)), $urandom,
                     1'b1, 5'(1 + $urandom_range(0, 30)), $urandom, '0);
        if (busy !== 1'b1 || ld_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL stall_full: got busy %0b ld_ready %0b expected 1 0", busy, ld_ready);
        end
        compared++;
        idle_cycles(5);
    endtask

    task automatic test_addr_zero();
        do_cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hFF, '0);
        idle_cycles(1);
        if (rf_we !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL addr_zero: got rf_we %0b busy %0b expected 0 0", rf_we, busy);
        end
        compared++;
        idle_cycles(1);
    endtask

    task automatic test_chk_hit();
        do_cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd9, 32'h99, 5'd9);
        do_cycle(1'b1, 5'd4, 32'hB, 1'b0, '0, '0, 5'd9);
        do_cycle(1'b1, 5'd4, 32'hC, 1'b0, '0, '0, 5'd0);
        do_cycle(1'b1, 5'd4, 32'hD, 1'b0, '0, '0, 5'd10);
        idle_cycles(2);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, 5'd2, $urandom, 1'b1, 5'(11 + i), $urandom, '0);
        alu_valid = 1'b1; ld_valid = 1'b1; chk_addr = 5'd11;
        rst_n = 1'b0;
        #1;
        if ({busy, ld_ready, rf_we, chk_hit} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got busy/ld_ready/rf_we/chk_hit=%b expected 0000", {busy, ld_ready, rf_we, chk_hit});
        end
        compared++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
    endtask

    task automatic test_random();
        logic          av, lv;
        logic [AW-1:0] ca;
        for (int i = 0; i < 400; i++) begin
            av = ($urandom_range(0, 9) < 4);
            lv = ($urandom_range(0, 9) < 6);
            ca = 5'($urandom_range(0, 31));
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                ca = mq[$urandom_range(0, mq.size() - 1)].a;
            do_cycle(av, 5'($urandom_range(0, 31)), $urandom,
                     lv, 5'($urandom_range(0, 31)), $urandom, ca);
        end
        idle_cycles(DEPTH + 1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_alu_write();
        test_load_latency();
        test_back_to_back();
        test_addr_zero();
        test_chk_hit();
        test_mid_reset();
        test_random();
`ifdef WB_STALL_COUNT_EN
        if (stall_count !== m_stall) begin
            mismatched++;
            $display("[TB] FAIL stall_count: got %0d expected %0d", stall_count, m_stall);
        end
        compared++;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width.
REQ-002 Parameter ADDRESS_WIDTH, default 5, register address width.
REQ-003 Parameter DEPTH, default 4, load-return FIFO entries, power of two, at least 2.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 alu_valid  in  1  ALU result present this cycle; cannot be stalled.
REQ-007 alu_addr / alu_data  in  ADDRESS_WIDTH / DATA_WIDTH  ALU destination and result.
REQ-008 ld_valid  in  1  load response present.
REQ-009 ld_ready  out  1  FIFO can accept a load response.
REQ-010 ld_addr / ld_data  in  ADDRESS_WIDTH / DATA_WIDTH  load destination and data.
REQ-011 rf_we / rf_waddr / rf_wdata  out  1 / ADDRESS_WIDTH / DATA_WIDTH  registered register-file write port.
REQ-012 chk_addr  in  ADDRESS_WIDTH  decode-stage hazard query address.
REQ-013 chk_hit  out  1  combinational; chk_addr is nonzero and matches a valid FIFO entry.
REQ-014 busy  out  1  FIFO non-empty.

Function
REQ-015 The block SHALL accept a load when ld_valid && ld_ready; ld_ready = (count < DEPTH) && rst_n.
REQ-016 The block SHALL store accepted loads in an in-order FIFO; push at the posedge of acceptance.
REQ-017 Each cycle, the block SHALL select a write source with ALU priority: alu_valid wins; otherwise pop the FIFO head if non-empty; otherwise no write.
REQ-018 Latency: ALU result at cycle N SHALL appear on rf_* at N+1.
REQ-019 Latency: load accepted at N SHALL be poppable at earliest N+1, appearing on rf_* at N+2.
REQ-020 The block SHALL NOT let an accepted load bypass the FIFO, even when the FIFO is empty.
REQ-021 A selected write with address 0 SHALL drive rf_we=0 but SHALL still be consumed (FIFO pops).
REQ-022 rf_waddr/rf_wdata SHALL hold their last values when rf_we=0.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; both SHALL occur.
REQ-024 When full with a pop in the same cycle, ld_ready SHALL still be 0 (no same-cycle refill).
REQ-025 Pointers SHALL wrap modulo DEPTH; count SHALL have range 0..DEPTH inclusive.
REQ-026 The block SHALL NOT reorder or merge ALU and load writes to the same address.
REQ-027 The issuer SHALL avoid same-address ALU/load conflicts using chk_hit.
REQ-028 chk_hit SHALL reflect FIFO contents before this cycle's push/pop.

Reset
REQ-029 While rst_n is low, count, pointers and rf_we SHALL be 0, and rf_waddr and rf_wdata SHALL be 0.
REQ-030 While rst_n is low, ld_ready, busy and chk_hit SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all FIFO entries immediately.
REQ-032 Reset asserted mid-operation SHALL cancel any in-flight rf_we.
REQ-033 FIFO data storage need not be cleared by reset.

Configuration
REQ-034 With macro WB_STALL_COUNT_EN defined, the block SHALL provide an extra output stall_count, 32 bits, reset 0.
REQ-035 stall_count SHALL increment once per cycle in which alu_valid=1 and the FIFO is non-empty, saturating at 32'hFFFFFFFF.
REQ-036 Without WB_STALL_COUNT_EN, the stall_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Reset release, then alu_valid=1, alu_addr=5, alu_data=32'hDEADBEEF for one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF.
REQ-038 Load addr=7, data=32'h11 accepted at N with no ALU traffic -> rf_we=1, rf_waddr=7 at N+2; busy=1 at N+1, busy=0 at N+2.
REQ-039 Back-to-back stall: alu_valid held 1 while DEPTH=4 loads arrive -> ld_ready=0 after the 4th accept.
REQ-040 After the stall drops, the FIFO SHALL drain in order over 4 cycles; with WB_STALL_COUNT_EN, stall_count equals the blocked cycles.
REQ-041 Load addr=0 data=32'hFF -> consumed, rf_we stays 0, busy returns to 0.
REQ-042 Load addr=9 pending, chk_addr=9 -> chk_hit=1; chk_addr=0 -> chk_hit=0; assert rst_n=0 with 3 entries -> busy=0, ld_ready=0, rf_we=0 immediately.
